// File: rtl/control_stage.sv
// -----------------------------------------------------------------------------
// control_stage
//
// Decode-and-issue stage of the pipelined RV32 core. The instruction held in
// the IF/ID register is decoded into the core's control word, and that word is
// registered into the ID/EX pipeline register. This stage also handles:
//   - load-use hazards: one bubble is inserted, and PC and IF/ID hold;
//   - taken branches and jumps: IF/ID is flushed and a bubble is inserted;
//   - multi-cycle M-extension ops: ID/EX holds while the op occupies EX.
//
// Parameters
//   ALU_OP_W    width of the ALU operation class code
//   EN_MEXT     1 = decode RV32M (R-type, FUNC7=0000001); 0 = such are illegal
//   MULDIV_LAT  total EX cycles occupied by an M-extension op (1..15)
//
// Ports
//   CLK, RESET           clock; synchronous active-high reset
//   IF_ID_VALID, INSTR   IF/ID register contents
//   BRANCH_TAKEN         EX-stage branch/jump resolved taken this cycle
//   STALL, FLUSH         combinational hold / invalidate for PC and IF/ID
//   EX_*                 registered ID/EX control word
//   DBG_STATE, DBG_CNT   FSM state (1 = MD_WAIT) and occupancy counter
//
// Flow control
//   The upstream PC and IF/ID registers consume the IF/ID instruction on a
//   rising edge only when STALL=0 and FLUSH=0. When STALL=1 they hold. When
//   FLUSH=1 the IF/ID contents are discarded. The two outputs are never both
//   high in the same cycle.
// -----------------------------------------------------------------------------
module control_stage #(
    parameter int ALU_OP_W   = 3,
    parameter int EN_MEXT    = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IF_ID_VALID,
    input  logic [31:0]         INSTR,
    input  logic                BRANCH_TAKEN,
    output logic                STALL,
    output logic                FLUSH,
    output logic                EX_VALID,
    output logic                EX_WRITE_ENABLE,
    output logic                EX_MEM_WRITE,
    output logic                EX_MEM_READ,
    output logic                EX_BRANCH,
    output logic                EX_JUMP,
    output logic                EX_MUX_1_IMM_SELECT,
    output logic                EX_MUX_2_PC_SELECT,
    output logic                EX_MUX_3_JAL_SELECT,
    output logic                EX_MUX_4_DATA_MEM_SELECT,
    output logic [ALU_OP_W-1:0] EX_ALU_OP,
    output logic [4:0]          EX_RD,
    output logic [2:0]          EX_FUNC3,
    output logic                EX_MULDIV,
    output logic                EX_ILLEGAL,
    output logic                DBG_STATE,
    output logic [3:0]          DBG_CNT
);

    // Major opcodes.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU operation classes.
    localparam logic [ALU_OP_W-1:0] ALU_RTYPE  = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] ALU_LOAD   = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] ALU_JALR   = ALU_OP_W'(3'b010);
    localparam logic [ALU_OP_W-1:0] ALU_OPIMM  = ALU_OP_W'(3'b011);
    localparam logic [ALU_OP_W-1:0] ALU_ADDR   = ALU_OP_W'(3'b100);
    localparam logic [ALU_OP_W-1:0] ALU_LUI    = ALU_OP_W'(3'b101);
    localparam logic [ALU_OP_W-1:0] ALU_MULDIV = ALU_OP_W'(3'b110);

    // On entry to MD_WAIT the counter is loaded with the number of
    // cycles that remain after the issue cycle.
    localparam logic [3:0] MD_CNT_INIT = 4'(MULDIV_LAT - 1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic                mem_write;
        logic                mem_read;
        logic                branch;
        logic                jump;
        logic                mux1;
        logic                mux2;
        logic                mux3;
        logic                mux4;
        logic [ALU_OP_W-1:0] alu_op;
        logic [4:0]          rd;
        logic [2:0]          func3;
        logic                muldiv;
        logic                illegal;
    } ctrl_t;

    // Instruction fields.
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] func3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] func7;

    assign opcode = INSTR[6:0];
    assign rd     = INSTR[11:7];
    assign func3  = INSTR[14:12];
    assign rs1    = INSTR[19:15];
    assign rs2    = INSTR[24:20];
    assign func7  = INSTR[31:25];

    state_t     state_q;
    logic [3:0] cnt_q;
    ctrl_t      ex_q;

    ctrl_t      ctrl_d;
    logic       rs1_used;
    logic       rs2_used;
    logic       legal;
    logic       load_use;
    logic       in_run;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    always_comb begin
        ctrl_d   = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        legal    = 1'b1;

        unique case (opcode)
            OP_R: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                if (func7 == F7_MULDIV) begin
                    if (EN_MEXT != 0) begin
                        ctrl_d.we     = 1'b1;
                        ctrl_d.alu_op = ALU_MULDIV;
                        ctrl_d.muldiv = 1'b1;
                    end else begin
                        legal = 1'b0;
                    end
                end else begin
                    ctrl_d.we     = 1'b1;
                    ctrl_d.alu_op = ALU_RTYPE;
                end
            end
            OP_LOAD: begin
                rs1_used = 1'b1;
                if (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    ctrl_d.we       = 1'b1;
                    ctrl_d.mem_read = 1'b1;
                    ctrl_d.mux1     = 1'b1;
                    ctrl_d.mux4     = 1'b1;
                    ctrl_d.alu_op   = ALU_LOAD;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_JALR: begin
                rs1_used = 1'b1;
                if (func3 == 3'b000) begin
                    ctrl_d.we     = 1'b1;
                    ctrl_d.mux3   = 1'b1;
                    ctrl_d.mux1   = 1'b1;
                    ctrl_d.jump   = 1'b1;
                    ctrl_d.alu_op = ALU_JALR;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_IMM: begin
                rs1_used = 1'b1;
                // Shifts constrain FUNC7; every other FUNC3 except the two
                // shift codes is a plain immediate op.
                if ((func3 inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111}) ||
                    (func3 == 3'b001 && func7 == F7_ZERO) ||
                    (func3 == 3'b101 && (func7 == F7_ZERO || func7 == F7_ALT))) begin
                    ctrl_d.we     = 1'b1;
                    ctrl_d.mux1   = 1'b1;
                    ctrl_d.alu_op = ALU_OPIMM;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                if (func3 <= 3'b010) begin
                    ctrl_d.mem_write = 1'b1;
                    ctrl_d.mux1      = 1'b1;
                    ctrl_d.alu_op    = ALU_ADDR;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_LUI: begin
                ctrl_d.we     = 1'b1;
                ctrl_d.mux1   = 1'b1;
                ctrl_d.alu_op = ALU_LUI;
            end
            OP_AUIPC: begin
                ctrl_d.we     = 1'b1;
                ctrl_d.mux1   = 1'b1;
                ctrl_d.mux2   = 1'b1;
                ctrl_d.alu_op = ALU_ADDR;
            end
            OP_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                if (!(func3 inside {3'b010, 3'b011})) begin
                    ctrl_d.branch = 1'b1;
                    ctrl_d.mux1   = 1'b1;
                    ctrl_d.mux2   = 1'b1;
                    ctrl_d.alu_op = ALU_ADDR;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_JAL: begin
                ctrl_d.jump   = 1'b1;
                ctrl_d.mux1   = 1'b1;
                ctrl_d.mux2   = 1'b1;
                ctrl_d.mux3   = 1'b1;
                ctrl_d.we     = 1'b1;
                ctrl_d.alu_op = ALU_ADDR;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // An undecodable word carries no control bits, only the flag.
        if (!legal) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
        end

        ctrl_d.valid = 1'b1;
        ctrl_d.rd    = rd;
        ctrl_d.func3 = func3;

        // An empty IF/ID slot decodes to a full bubble.
        if (!IF_ID_VALID) begin
            ctrl_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Hazard detection and flow control
    // -------------------------------------------------------------------------
    // Loads to x0 produce nothing to forward, so they never stall.
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && IF_ID_VALID &&
                      ((rs1_used && (rs1 == ex_q.rd)) || (rs2_used && (rs2 == ex_q.rd)));

    assign in_run = (state_q == ST_RUN);

    // A taken branch in RUN wins over load-use, so the two never coincide.
    // While in MD_WAIT the branch input is ignored.
    assign FLUSH = in_run && BRANCH_TAKEN;
    assign STALL = !in_run || (!BRANCH_TAKEN && load_use);

    // -------------------------------------------------------------------------
    // FSM and ID/EX register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            ex_q    <= '0;
        end else begin
            unique case (state_q)
                ST_MD_WAIT: begin
                    // ID/EX holds while the M-op occupies EX.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    if (BRANCH_TAKEN || load_use) begin
                        ex_q <= '0;
                    end else begin
                        ex_q <= ctrl_d;
                        if (ctrl_d.muldiv && (MULDIV_LAT > 1)) begin
                            state_q <= ST_MD_WAIT;
                            cnt_q   <= MD_CNT_INIT;
                        end
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign EX_VALID                 = ex_q.valid;
    assign EX_WRITE_ENABLE          = ex_q.we;
    assign EX_MEM_WRITE             = ex_q.mem_write;
    assign EX_MEM_READ              = ex_q.mem_read;
    assign EX_BRANCH                = ex_q.branch;
    assign EX_JUMP                  = ex_q.jump;
    assign EX_MUX_1_IMM_SELECT      = ex_q.mux1;
    assign EX_MUX_2_PC_SELECT       = ex_q.mux2;
    assign EX_MUX_3_JAL_SELECT      = ex_q.mux3;
    assign EX_MUX_4_DATA_MEM_SELECT = ex_q.mux4;
    assign EX_ALU_OP                = ex_q.alu_op;
    assign EX_RD                    = ex_q.rd;
    assign EX_FUNC3                 = ex_q.func3;
    assign EX_MULDIV                = ex_q.muldiv;
    assign EX_ILLEGAL               = ex_q.illegal;

    assign DBG_STATE = (state_q == ST_MD_WAIT);
    assign DBG_CNT   = cnt_q;

endmodule
